// File: rtl/mac_accum.sv
// Packet accumulator behind the multiply-add datapath: sums valid/ready terms
// until in_last, then holds sum, term count and wrap flag until consumed.
module mac_accum #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 12,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int                 PAD     = ACC_WIDTH - WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   oovf_q, oovf_d;

    logic [ACC_WIDTH-1:0]   term_ext;
    logic [ACC_WIDTH:0]     acc_plus;
    logic [ACC_WIDTH-1:0]   upd_acc;
    logic [CNT_WIDTH-1:0]   upd_cnt;
    logic                   upd_ovf;
    logic                   in_xfer;

    // in_ready decodes registered state only, so out_ready never reaches it
    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = sum_q;
    assign out_count = count_q;
    assign out_ovf   = oovf_q;

    assign in_xfer  = in_valid && in_ready;
    assign term_ext = {{PAD{1'b0}}, in_data};
    assign acc_plus = {1'b0, acc_q} + {1'b0, term_ext};

    always_comb begin
        upd_acc = term_ext;
        upd_cnt = CNT_ONE;
        upd_ovf = 1'b0;
        if (state_q == ACC) begin
            upd_acc = acc_plus[ACC_WIDTH-1:0];
            upd_ovf = ovf_q | acc_plus[ACC_WIDTH];
            upd_cnt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum_d   = sum_q;
        count_d = count_q;
        oovf_d  = oovf_q;
        case (state_q)
            IDLE, ACC: begin
                if (in_xfer) begin
                    acc_d = upd_acc;
                    cnt_d = upd_cnt;
                    ovf_d = upd_ovf;
                    if (in_last) begin
                        state_d = HOLD;
                        sum_d   = upd_acc;
                        count_d = upd_cnt;
                        oovf_d  = upd_ovf;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            oovf_q  <= oovf_d;
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// Scoreboard bench for mac_accum: packet-level arithmetic model feeds a queue,
// a negedge monitor checks every presented result and handshake timing.
module tb_mac_accum;

    localparam int WIDTH     = 4;
    localparam int ACC_WIDTH = 12;
    localparam int CNT_WIDTH = 8;
    localparam int ACC_MOD   = 1 << ACC_WIDTH;
    localparam int CNT_SAT   = (1 << CNT_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;

    typedef struct {
        int sum;
        int cnt;
        int ovf;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   ready_mode = 1;   // 0 low, 1 high, 2 random
    int   pkt_total = 0;
    int   pkt_terms = 0;
    bit   pend_last = 1'b0;

    mac_accum #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pend_last = 1'b0;
        end else begin
            if (pend_last) chk("latency_out_valid", int'(out_valid), 1);
            chk("in_ready_vs_hold", int'(in_ready), int'(!out_valid));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    chk("out_sum", int'(out_sum), q[0].sum);
                    chk("out_count", int'(out_count), q[0].cnt);
                    chk("out_ovf", int'(out_ovf), q[0].ovf);
                    if (out_ready) void'(q.pop_front());
                end
            end
            pend_last = in_valid && in_ready && in_last;
        end
    end

    // Model: a packet result is the plain integer total reduced mod 2^ACC_WIDTH;
    // it wrapped iff the total reached 2^ACC_WIDTH, since every term is unsigned.
    task automatic send(input int d, input bit last);
        int  waited = 0;
        bit  got = 1'b0;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d[WIDTH-1:0];
        in_last  = last;
        while (!got && waited < 500) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!got) begin
            chk("send_timeout", 0, 1);
        end else begin
            pkt_total += d;
            pkt_terms++;
            if (last) begin
                e.sum = pkt_total % ACC_MOD;
                e.cnt = (pkt_terms > CNT_SAT) ? CNT_SAT : pkt_terms;
                e.ovf = (pkt_total >= ACC_MOD) ? 1 : 0;
                q.push_back(e);
                pkt_total = 0;
                pkt_terms = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() != 0 && w < 1000) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        out_ready = 1'b1;
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_sum", int'(out_sum), 0);
        chk("reset_out_count", int'(out_count), 0);
        chk("reset_out_ovf", int'(out_ovf), 0);
        @(posedge clk);
        #1;

        send(3, 0); send(5, 0); send(7, 1);
        drain();

        send(9, 1); send(4, 1);
        drain();

        for (int i = 1; i <= 300; i++) send(15, i == 300);
        drain();

        send(2, 0);
        ready_mode = 0;
        send(2, 1);
        in_valid = 1'b1;
        in_data  = 4'd1;
        in_last  = 1'b1;
        idle(5);
        chk("hold_out_valid", int'(out_valid), 1);
        chk("hold_in_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        ready_mode = 1;
        send(5, 1);
        drain();

        send(6, 0); send(6, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_out_sum", int'(out_sum), 0);
        chk("async_rst_out_count", int'(out_count), 0);
        chk("async_rst_out_ovf", int'(out_ovf), 0);
        chk("async_rst_in_ready", int'(in_ready), 1);
        #2;
        rst_n = 1'b1;
        pkt_total = 0;
        pkt_terms = 0;
        idle(1);
        send(1, 1);
        drain();

        send(8, 0);
        idle(3);
        send(8, 1);
        drain();

        ready_mode = 2;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int t = 1; t <= len; t++) begin
                send($urandom_range(0, 15), t == len);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        ready_mode = 1;
        drain();

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mac_accum.md
# mac_accum

Sequential accumulation stage placed directly downstream of the combinational multiply-add datapath, whose result is `arg1*arg2 + arg3` truncated to WIDTH bits. It consumes a stream of WIDTH-bit results over a valid/ready handshake and sums each packet, delimited by `in_last`, into a wider accumulator. It then presents the packet sum, term count and overflow flag on an output valid/ready handshake, holding them until they are consumed.

## Interface
- WIDTH, 4, width of each incoming term (matches datapath result width)
- ACC_WIDTH, 12, accumulator/sum width; must be > WIDTH
- CNT_WIDTH, 8, term-counter width
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream term valid
- in_ready  output  1  stage can accept a term
- in_data  input  WIDTH  term, unsigned
- in_last  input  1  term is the final one of its packet
- out_valid  output  1  packet result available
- out_ready  input  1  downstream accepts result
- out_sum  output  ACC_WIDTH  packet sum, modulo 2^ACC_WIDTH
- out_count  output  CNT_WIDTH  terms in packet, saturating
- out_ovf  output  1  sticky: sum wrapped at least once in this packet

## Operation
- States: IDLE (no partial packet), ACC (partial packet in accumulator), HOLD (result presented).
- Input transfer = `in_valid && in_ready`; `in_ready = (state != HOLD)`, registered-state decode, with no combinational path from `out_ready`.
- Transfer in IDLE: acc <= zero-extended in_data; cnt <= 1; ovf <= 0.
- Transfer in ACC: acc <= acc + zero-extended in_data, with the carry out of bit ACC_WIDTH-1 discarded; ovf <= ovf | carry; cnt <= cnt+1, saturating at 2^CNT_WIDTH-1.
- Transfer with in_last=0: go to ACC. Transfer with in_last=1: go to HOLD, loading out_sum/out_count/out_ovf with the updated values, including this term.
- Single-term packet (IDLE transfer with in_last=1): out_sum=in_data, out_count=1, out_ovf=0.
- HOLD: out_valid=1; out_sum/out_count/out_ovf are stable until the output transfer (`out_valid && out_ready`), after which the next state is IDLE. in_valid is ignored in HOLD, and no data is captured.
- When not in HOLD, out_valid=0; out_sum/out_count/out_ovf keep their last presented values.
- in_data/in_last are sampled only on input transfer; values without in_valid are don't-care.

## Timing
- Reset (rst_n low, asynchronous, any cycle including mid-packet or in HOLD): state=IDLE, acc/cnt/ovf=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1 from the first edge after deassertion. Any partial packet is discarded.
- Latency: out_valid rises on the clock edge that accepts the in_last term, i.e. it is visible in the next cycle.
- in_ready is low for every cycle out_valid is high, including the consume cycle. It returns high the cycle after the output transfer, so there is a one-cycle bubble per packet.
- Maximum throughput: one term per cycle within a packet; single-term packets every 2 cycles.
- out_ready held low in HOLD: stage stalls indefinitely with outputs frozen.
- out_ready high outside HOLD: no effect.

## Test plan
- Reset, then terms 3,5,7 (last on 7), out_ready=1 -> out_valid one cycle after the 7 is accepted; sum=15, count=3, ovf=0; in_ready low that cycle, high next.
- Single-term packet: in_data=9, in_last=1 -> sum=9, count=1, ovf=0; a back-to-back packet of 4 (last) -> sum=4, count=1, showing the accumulator restarted.
- Overflow/saturation: 300 terms of 15, last on the 300th -> sum=404 (4500 mod 4096), ovf=1, count=255.
- Backpressure: complete packet 2,2 (last), hold out_ready=0 for 5 cycles while driving in_valid=1, in_data=1 -> sum=4/count=2 stable, in_ready=0, no term absorbed; raise out_ready -> next packet starts from zero.
- Reset mid-packet: accept 6,6 without last, pulse rst_n low asynchronously between edges -> all outputs 0 immediately; then 1 (last) -> sum=1, count=1.
- Gaps: packet 8, idle 3 cycles with in_valid=0, then 8 (last) -> sum=16, count=2, ovf=0.
